// File: rtl/delay_line_ctrl.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : delay_line_ctrl
// Purpose  : Programmable sample delay line controller. Sits in front of an
//            external synchronous FIFO (no reset of its own) and keeps the
//            FIFO occupancy equal to the requested delay, so every emitted
//            sample is the input sample from d_eff strobes earlier.
//            After reset the FIFO is flushed of stale words before any
//            samples are accepted.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
// Ports
//   clk              in   1      clock, rising edge
//   rst_n            in   1      synchronous reset, active low
//   i_in_valid       in   1      one-cycle sample strobe (min spacing 2 cycles)
//   i_in_data        in   WIDTH  sample, valid with i_in_valid
//   i_delay          in   CNT_W  requested delay in samples (clamped to DEPTH-1)
//   o_out_valid      out  1      one-cycle strobe, delayed sample on o_out_data
//   o_out_data       out  WIDTH  delayed sample, held until next o_out_valid
//   o_level          out  CNT_W  tracked FIFO occupancy
//   o_state          out  3      FSM state (debug)
//   o_err            out  1      sticky FIFO misuse flag
//   o_fifo_data_in   out  WIDTH  to FIFO data_in
//   o_fifo_wr_en     out  1      to FIFO wr_en
//   o_fifo_rd_en     out  1      to FIFO rd_en
//   i_fifo_data_out  in   WIDTH  from FIFO, valid the cycle after a read edge
//   i_fifo_empty     in   1      from FIFO
//   i_fifo_full      in   1      from FIFO
//------------------------------------------------------------------------------
module delay_line_ctrl #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 10,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_in_valid,
  input  logic [WIDTH-1:0] i_in_data,
  input  logic [CNT_W-1:0] i_delay,
  output logic             o_out_valid,
  output logic [WIDTH-1:0] o_out_data,
  output logic [CNT_W-1:0] o_level,
  output logic [2:0]       o_state,
  output logic             o_err,
  output logic [WIDTH-1:0] o_fifo_data_in,
  output logic             o_fifo_wr_en,
  output logic             o_fifo_rd_en,
  input  logic [WIDTH-1:0] i_fifo_data_out,
  input  logic             i_fifo_empty,
  input  logic             i_fifo_full
);

  typedef enum logic [2:0] {
    ST_FLUSH  = 3'd0,
    ST_BYPASS = 3'd1,
    ST_FILL   = 3'd2,
    ST_RUN    = 3'd3,
    ST_DRAIN  = 3'd4
  } state_t;

  localparam logic [CNT_W-1:0] c_MAX_DELAY = CNT_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] c_ONE       = CNT_W'(1);

  state_t             r_state;
  logic [CNT_W-1:0]   r_level;
  logic [CNT_W-1:0]   r_d_eff;
  logic               r_out_valid;
  logic [WIDTH-1:0]   r_out_data;
  logic               r_emit_fifo;
  logic               r_err;

  logic [CNT_W-1:0]   w_d_eff_next;
  logic [CNT_W-1:0]   w_level_next;
  state_t             w_state_next;
  logic               w_wr_en;
  logic               w_rd_en;
  logic               w_emit_fifo;
  logic               w_bypass;

  assign w_d_eff_next = (i_delay > c_MAX_DELAY) ? c_MAX_DELAY : i_delay;

  //--------------------------------------------------------------------------
  // FIFO strobes and occupancy update. Everything is gated by rst_n so the
  // FIFO is left untouched while reset is asserted, whatever the state
  // register held before reset was sampled.
  //--------------------------------------------------------------------------
  always_comb begin
    w_wr_en      = 1'b0;
    w_rd_en      = 1'b0;
    w_emit_fifo  = 1'b0;
    w_bypass     = 1'b0;
    w_level_next = r_level;
    w_state_next = r_state;

    if (rst_n) begin
      case (r_state)
        ST_FLUSH: begin
          // stale words are read out and discarded; strobes are dropped
          w_rd_en = !i_fifo_empty;
        end
        ST_BYPASS: begin
          w_bypass = i_in_valid;
        end
        ST_FILL: begin
          if (i_in_valid) begin
            w_wr_en      = 1'b1;
            w_level_next = r_level + c_ONE;
          end
        end
        ST_RUN: begin
          if (i_in_valid) begin
            w_wr_en     = 1'b1;
            w_rd_en     = 1'b1;
            w_emit_fifo = 1'b1;
          end
        end
        ST_DRAIN: begin
          if (i_in_valid) begin
            w_wr_en     = 1'b1;
            w_rd_en     = 1'b1;
            w_emit_fifo = 1'b1;
          end else begin
            // idle cycle: shed one surplus word
            w_rd_en      = 1'b1;
            w_level_next = r_level - c_ONE;
          end
        end
        default: begin
          w_state_next = ST_FLUSH;
        end
      endcase

      // The next state is classified against the d_eff value that will be
      // registered on this same edge, so state, level and d_eff always agree
      // in the following cycle and the per-state actions above stay valid.
      if (r_state == ST_FLUSH) begin
        if (i_fifo_empty) begin
          w_state_next = (w_d_eff_next == '0) ? ST_BYPASS : ST_FILL;
        end
      end else if (r_state inside {ST_BYPASS, ST_FILL, ST_RUN, ST_DRAIN}) begin
        if (w_level_next == w_d_eff_next) begin
          w_state_next = (w_d_eff_next == '0) ? ST_BYPASS : ST_RUN;
        end else if (w_level_next < w_d_eff_next) begin
          w_state_next = ST_FILL;
        end else begin
          w_state_next = ST_DRAIN;
        end
      end
    end
  end

  //--------------------------------------------------------------------------
  // State and registered outputs
  //--------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= ST_FLUSH;
      r_level     <= '0;
      r_d_eff     <= '0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_emit_fifo <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_level     <= w_level_next;
      r_d_eff     <= w_d_eff_next;
      r_out_valid <= w_bypass | w_emit_fifo;
      r_emit_fifo <= w_emit_fifo;

      // Bypass samples are captured directly. FIFO samples only appear on
      // i_fifo_data_out during the out_valid cycle, so they are captured at
      // the end of it and held from then on, independent of later discard
      // reads that change the FIFO output.
      if (w_bypass) begin
        r_out_data <= i_in_data;
      end else if (r_emit_fifo) begin
        r_out_data <= i_fifo_data_out;
      end

      if ((w_wr_en && i_fifo_full) || (w_rd_en && i_fifo_empty)) begin
        r_err <= 1'b1;
      end
    end
  end

  // During the out_valid cycle of a FIFO-sourced sample the data is passed
  // straight from the FIFO output; this is what gives one-cycle latency.
  assign o_out_data     = r_emit_fifo ? i_fifo_data_out : r_out_data;
  assign o_out_valid    = r_out_valid;
  assign o_level        = r_level;
  assign o_state        = r_state;
  assign o_err          = r_err;
  assign o_fifo_data_in = i_in_data;
  assign o_fifo_wr_en   = w_wr_en;
  assign o_fifo_rd_en   = w_rd_en;

endmodule
`default_nettype wire

// File: tb/tb_delay_line_ctrl.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : tb_delay_line_ctrl
// Purpose  : Directed self-checking bench for delay_line_ctrl, with a small
//            behavioural model of the reset-less synchronous FIFO attached.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
module tb_delay_line_ctrl;

  localparam int WIDTH = 8;
  localparam int DEPTH = 10;
  localparam int CNT_W = 4;

  localparam logic [2:0] S_FLUSH  = 3'd0;
  localparam logic [2:0] S_BYPASS = 3'd1;
  localparam logic [2:0] S_FILL   = 3'd2;
  localparam logic [2:0] S_RUN    = 3'd3;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid;
  logic [WIDTH-1:0] in_data;
  logic [CNT_W-1:0] delay;
  logic             out_valid;
  logic [WIDTH-1:0] out_data;
  logic [CNT_W-1:0] level;
  logic [2:0]       state;
  logic             err;
  logic [WIDTH-1:0] fifo_data_in;
  logic             fifo_wr_en;
  logic             fifo_rd_en;
  logic [WIDTH-1:0] fifo_data_out;
  logic             fifo_empty;
  logic             fifo_full;

  // bench-side preload port into the FIFO model
  logic             tb_wr;
  logic [WIDTH-1:0] tb_data;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  delay_line_ctrl #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .i_in_valid      (in_valid),
    .i_in_data       (in_data),
    .i_delay         (delay),
    .o_out_valid     (out_valid),
    .o_out_data      (out_data),
    .o_level         (level),
    .o_state         (state),
    .o_err           (err),
    .o_fifo_data_in  (fifo_data_in),
    .o_fifo_wr_en    (fifo_wr_en),
    .o_fifo_rd_en    (fifo_rd_en),
    .i_fifo_data_out (fifo_data_out),
    .i_fifo_empty    (fifo_empty),
    .i_fifo_full     (fifo_full)
  );

  // ---------------- FIFO model (no reset, registered read data) -------------
  logic [WIDTH-1:0] f_mem [DEPTH];
  int               f_wp  = 0;
  int               f_rp  = 0;
  int               f_cnt = 0;
  logic             f_we;
  logic [WIDTH-1:0] f_din;
  logic             f_do_w;
  logic             f_do_r;

  assign f_we       = (fifo_wr_en === 1'b1) || (tb_wr === 1'b1);
  assign f_din      = tb_wr ? tb_data : fifo_data_in;
  assign fifo_empty = (f_cnt == 0);
  assign fifo_full  = (f_cnt == DEPTH);
  assign f_do_w     = f_we && !fifo_full;
  assign f_do_r     = (fifo_rd_en === 1'b1) && !fifo_empty;

  always @(posedge clk) begin
    if (f_do_w) begin
      f_mem[f_wp] <= f_din;
      f_wp        <= (f_wp == DEPTH - 1) ? 0 : f_wp + 1;
    end
    if (f_do_r) begin
      fifo_data_out <= f_mem[f_rp];
      f_rp          <= (f_rp == DEPTH - 1) ? 0 : f_rp + 1;
    end
    f_cnt <= f_cnt + (f_do_w ? 1 : 0) - (f_do_r ? 1 : 0);
  end

  // ---------------- activity counters (sampled mid-cycle) -------------------
  int c_wr = 0, c_rd = 0, c_ov = 0, c_full = 0;
  int b_wr, b_rd, b_ov;

  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (fifo_wr_en === 1'b1) c_wr <= c_wr + 1;
      if (fifo_rd_en === 1'b1) c_rd <= c_rd + 1;
      if (out_valid === 1'b1)  c_ov <= c_ov + 1;
    end
    if (fifo_full) c_full <= c_full + 1;
  end

  // ---------------- helpers -------------------------------------------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      $error("check %s", tag);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic snap();
    b_wr = c_wr;
    b_rd = c_rd;
    b_ov = c_ov;
  endtask

  // one strobe, check the cycle after it, then idle so strobes are 4 apart
  task automatic strobe(input logic [7:0] d, input logic ev, input logic [7:0] ed,
                        input string tag);
    in_valid = 1'b1;
    in_data  = d;
    tick(1);
    in_valid = 1'b0;
    check({tag, "_ov"}, {31'd0, out_valid}, {31'd0, ev});
    if (ev) check({tag, "_od"}, {24'd0, out_data}, {24'd0, ed});
    tick(3);
  endtask

  // ---------------- directed sequence ---------------------------------------
  initial begin
    rst_n    = 1'b0;
    in_valid = 1'b0;
    in_data  = '0;
    delay    = '0;
    tb_wr    = 1'b0;
    tb_data  = '0;

    // 1. stale words in the FIFO, then reset release -> flush
    tick(1);
    tb_wr = 1'b1; tb_data = 8'hA1; tick(1);
    tb_data = 8'hA2; tick(1);
    tb_data = 8'hA3; tick(1);
    tb_wr = 1'b0;
    check("rst_state", {29'd0, state}, {29'd0, S_FLUSH});
    check("rst_level", {28'd0, level}, 32'd0);
    check("rst_ov",    {31'd0, out_valid}, 32'd0);
    check("rst_od",    {24'd0, out_data}, 32'd0);
    check("rst_err",   {31'd0, err}, 32'd0);
    snap();
    rst_n = 1'b1;
    tick(6);
    check("t1_rd",    c_rd - b_rd, 32'd3);
    check("t1_ov",    c_ov - b_ov, 32'd0);
    check("t1_state", {29'd0, state}, {29'd0, S_BYPASS});
    check("t1_err",   {31'd0, err}, 32'd0);

    // 2. zero delay bypass
    snap();
    strobe(8'h5A, 1'b1, 8'h5A, "t2");
    check("t2_wr",   c_wr - b_wr, 32'd0);
    check("t2_hold", {24'd0, out_data}, 32'h5A);
    check("t2_ov0",  {31'd0, out_valid}, 32'd0);

    // 3. delay of 3 samples
    delay = 4'd3;
    tick(2);
    check("t3_fill", {29'd0, state}, {29'd0, S_FILL});
    strobe(8'd1, 1'b0, 8'd0, "t3_s1");
    strobe(8'd2, 1'b0, 8'd0, "t3_s2");
    strobe(8'd3, 1'b0, 8'd0, "t3_s3");
    check("t3_run",  {29'd0, state}, {29'd0, S_RUN});
    strobe(8'd4, 1'b1, 8'd1, "t3_s4");
    strobe(8'd5, 1'b1, 8'd2, "t3_s5");
    strobe(8'd6, 1'b1, 8'd3, "t3_s6");
    check("t3_level", {28'd0, level}, 32'd3);

    // 4. mid-run reset with delay beyond range: flush 3, clamp to 9
    rst_n = 1'b0;
    delay = 4'd15;
    tick(1);
    rst_n = 1'b1;
    snap();
    tick(1);
    check("t4_flush", {29'd0, state}, {29'd0, S_FLUSH});
    tick(5);
    check("t4_fill",  {29'd0, state}, {29'd0, S_FILL});
    check("t4_rd",    c_rd - b_rd, 32'd3);
    check("t4_lvl0",  {28'd0, level}, 32'd0);
    for (int i = 0; i < 9; i++) strobe(8'h10 + 8'(i), 1'b0, 8'd0, "t4_fill_s");
    check("t4_lvl9",  {28'd0, level}, 32'd9);
    check("t4_run",   {29'd0, state}, {29'd0, S_RUN});
    check("t4_full",  c_full, 32'd0);
    check("t4_err",   {31'd0, err}, 32'd0);
    strobe(8'h19, 1'b1, 8'h10, "t4_first");

    // 5. shrink delay 9 -> 5 -> 2 with idle discard reads
    snap();
    delay = 4'd5;
    tick(8);
    check("t5_lvl5",  {28'd0, level}, 32'd5);
    check("t5_run5",  {29'd0, state}, {29'd0, S_RUN});
    check("t5_rd5",   c_rd - b_rd, 32'd4);
    check("t5_ov5",   c_ov - b_ov, 32'd0);
    check("t5_hold",  {24'd0, out_data}, 32'h10);
    snap();
    delay = 4'd2;
    tick(6);
    check("t5_lvl2",  {28'd0, level}, 32'd2);
    check("t5_run2",  {29'd0, state}, {29'd0, S_RUN});
    check("t5_rd2",   c_rd - b_rd, 32'd3);
    check("t5_ov2",   c_ov - b_ov, 32'd0);
    strobe(8'h20, 1'b1, 8'h18, "t5_a");
    strobe(8'h21, 1'b1, 8'h19, "t5_b");
    strobe(8'h22, 1'b1, 8'h20, "t5_c");

    // 6. grow delay 2 -> 4
    delay = 4'd4;
    tick(2);
    check("t6_fill",  {29'd0, state}, {29'd0, S_FILL});
    strobe(8'h23, 1'b0, 8'd0, "t6_a");
    strobe(8'h24, 1'b0, 8'd0, "t6_b");
    check("t6_run",   {29'd0, state}, {29'd0, S_RUN});
    check("t6_lvl",   {28'd0, level}, 32'd4);
    strobe(8'h25, 1'b1, 8'h21, "t6_c");
    strobe(8'h26, 1'b1, 8'h22, "t6_d");
    strobe(8'h27, 1'b1, 8'h23, "t6_e");

    // strobe during flush is dropped (4 stale words remain)
    rst_n = 1'b0;
    tick(1);
    rst_n = 1'b1;
    snap();
    strobe(8'hEE, 1'b0, 8'd0, "t6_flush");
    tick(4);
    check("t6f_wr",    c_wr - b_wr, 32'd0);
    check("t6f_ov",    c_ov - b_ov, 32'd0);
    check("t6f_rd",    c_rd - b_rd, 32'd4);
    check("t6f_level", {28'd0, level}, 32'd0);
    check("t6f_state", {29'd0, state}, {29'd0, S_FILL});
    check("end_err",   {31'd0, err}, 32'd0);
    check("end_full",  c_full, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
